// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and FSM encodings for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int WBA_WORD_LEN     = 32;
    localparam int WBA_REG_ADDR_LEN = 5;
    localparam int WBA_STARVE_CNT_W = 4;

    typedef enum logic [0:0] {
        WBA_NORMAL = 1'b0,
        WBA_STALL  = 1'b1
    } wba_state_e;

    typedef struct packed {
        logic [WBA_REG_ADDR_LEN-1:0] dest;
        logic [WBA_WORD_LEN-1:0]     data;
    } wba_entry_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending long-latency result FIFO; the head is visible without popping.
module wb_pend_fifo #(
    parameter int FIFO_DEPTH = 2,
    parameter int WIDTH      = 37
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify push/pop against the occupancy seen at the start of the cycle.
    always_comb begin
        o_full    = (count_r == CNT_W'(FIFO_DEPTH));
        o_empty   = (count_r == {CNT_W{1'b0}});
        push_ok_s = i_push & ~o_full;
        pop_ok_s  = i_pop & ~o_empty;
        o_head    = mem_r[rd_ptr_r];
    end

    // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care until counted as valid.
    always_ff @(posedge i_clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= i_push_data;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, long-latency
// results queue and drain into free slots, with a one-cycle stall against starvation.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int WORD_LEN     = WBA_WORD_LEN,
    parameter int REG_ADDR_LEN = WBA_REG_ADDR_LEN,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wb_valid,
    input  logic                    i_wb_reg_wr_en,
    input  logic                    i_wb_mem_rd_en,
    input  logic [WORD_LEN-1:0]     i_wb_mem_data,
    input  logic [WORD_LEN-1:0]     i_wb_alu_result,
    input  logic [REG_ADDR_LEN-1:0] i_wb_dest,
    input  logic                    i_lu_valid,
    input  logic [REG_ADDR_LEN-1:0] i_lu_dest,
    input  logic [WORD_LEN-1:0]     i_lu_data,
    output logic                    o_lu_ready,
    output logic                    o_rf_wr_en,
    output logic [REG_ADDR_LEN-1:0] o_rf_wr_addr,
    output logic [WORD_LEN-1:0]     o_rf_wr_data,
    output logic                    o_stall
);

    localparam int                          ENTRY_W   = REG_ADDR_LEN + WORD_LEN;
    localparam logic [WBA_STARVE_CNT_W-1:0] LIMIT_C   = WBA_STARVE_CNT_W'(STARVE_LIMIT);

    wba_state_e                  state_r;
    wba_state_e                  state_nxt_s;
    logic [WBA_STARVE_CNT_W-1:0] starve_cnt_r;
    logic [WBA_STARVE_CNT_W-1:0] starve_cnt_nxt_s;
    logic                        stall_s;
    logic                        pw_s;
    logic                        pop_s;
    logic                        push_s;
    logic                        full_s;
    logic                        empty_s;
    logic [WORD_LEN-1:0]         wb_data_s;
    logic [ENTRY_W-1:0]          push_entry_s;
    logic [ENTRY_W-1:0]          head_s;
    logic                        rf_wr_en_r;
    logic [REG_ADDR_LEN-1:0]     rf_wr_addr_r;
    logic [WORD_LEN-1:0]         rf_wr_data_r;

    wb_pend_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (ENTRY_W)
    ) u_pend_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (push_s),
        .i_push_data (push_entry_s),
        .i_pop       (pop_s),
        .o_full      (full_s),
        .o_empty     (empty_s),
        .o_head      (head_s)
    );

    // Source selection: a stalled or r0-bound pipeline slot counts as free.
    always_comb begin
        pw_s = i_wb_valid & i_wb_reg_wr_en
             & (i_wb_dest != {REG_ADDR_LEN{1'b0}}) & ~stall_s;
        if (i_wb_mem_rd_en) begin
            wb_data_s = i_wb_mem_data;
        end else begin
            wb_data_s = i_wb_alu_result;
        end
        pop_s        = ~pw_s & ~empty_s;
        // r0 results are accepted but dropped so they never occupy an entry.
        push_s       = i_lu_valid & ~full_s & (i_lu_dest != {REG_ADDR_LEN{1'b0}});
        push_entry_s = {i_lu_dest, i_lu_data};
    end

    assign o_lu_ready = ~full_s;

    // Starvation count: grows only while a NORMAL cycle leaves a waiting head blocked.
    always_comb begin
        starve_cnt_nxt_s = starve_cnt_r;
        if (empty_s || pop_s) begin
            starve_cnt_nxt_s = {WBA_STARVE_CNT_W{1'b0}};
        end else if (state_r == WBA_NORMAL) begin
            starve_cnt_nxt_s = starve_cnt_r + WBA_STARVE_CNT_W'(1);
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_cnt_r <= {WBA_STARVE_CNT_W{1'b0}};
        end else begin
            starve_cnt_r <= starve_cnt_nxt_s;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= WBA_NORMAL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: stall begins at the edge where the count reaches the limit.
    always_comb begin
        state_nxt_s = WBA_NORMAL;
        case (state_r)
            WBA_NORMAL: begin
                if (starve_cnt_nxt_s == LIMIT_C) begin
                    state_nxt_s = WBA_STALL;
                end else begin
                    state_nxt_s = WBA_NORMAL;
                end
            end
            WBA_STALL: state_nxt_s = WBA_NORMAL;
            default:   state_nxt_s = WBA_NORMAL;
        endcase
    end

    // FSM outputs.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            WBA_NORMAL: stall_s = 1'b0;
            WBA_STALL:  stall_s = 1'b1;
            default:    stall_s = 1'b0;
        endcase
    end

    assign o_stall = stall_s;

    // Write-port registers; address and data hold across idle slots.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rf_wr_en_r   <= 1'b0;
            rf_wr_addr_r <= {REG_ADDR_LEN{1'b0}};
            rf_wr_data_r <= {WORD_LEN{1'b0}};
        end else if (pw_s) begin
            rf_wr_en_r   <= 1'b1;
            rf_wr_addr_r <= i_wb_dest;
            rf_wr_data_r <= wb_data_s;
        end else if (pop_s) begin
            rf_wr_en_r   <= 1'b1;
            rf_wr_addr_r <= head_s[ENTRY_W-1:WORD_LEN];
            rf_wr_data_r <= head_s[WORD_LEN-1:0];
        end else begin
            rf_wr_en_r   <= 1'b0;
        end
    end

    assign o_rf_wr_en   = rf_wr_en_r;
    assign o_rf_wr_addr = rf_wr_addr_r;
    assign o_rf_wr_data = rf_wr_data_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random traffic,
// all checked against a queue-based reference model of the arbitration rules.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic        wb_wr_en;
    logic        wb_mem_rd;
    logic [31:0] wb_mem_data;
    logic [31:0] wb_alu;
    logic [4:0]  wb_dest;
    logic        lu_valid;
    logic [4:0]  lu_dest;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        stall;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .WORD_LEN     (32),
        .REG_ADDR_LEN (5),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_wb_valid      (wb_valid),
        .i_wb_reg_wr_en  (wb_wr_en),
        .i_wb_mem_rd_en  (wb_mem_rd),
        .i_wb_mem_data   (wb_mem_data),
        .i_wb_alu_result (wb_alu),
        .i_wb_dest       (wb_dest),
        .i_lu_valid      (lu_valid),
        .i_lu_dest       (lu_dest),
        .i_lu_data       (lu_data),
        .o_lu_ready      (lu_ready),
        .o_rf_wr_en      (rf_wr_en),
        .o_rf_wr_addr    (rf_wr_addr),
        .o_rf_wr_data    (rf_wr_data),
        .o_stall         (stall)
    );

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
    } ent_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    ent_t        q[$];
    int          m_wait;
    bit          m_stall;
    bit          exp_en;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    bit          last_stall;
    bit          last_ready;
    int          wr_log[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_wb(input bit v, input bit we, input bit mrd, input logic [4:0] d,
                          input logic [31:0] alu, input logic [31:0] mem);
        wb_valid = v; wb_wr_en = we; wb_mem_rd = mrd; wb_dest = d;
        wb_alu = alu; wb_mem_data = mem;
    endtask

    task automatic set_lu(input bit v, input logic [4:0] d, input logic [31:0] data);
        lu_valid = v; lu_dest = d; lu_data = data;
    endtask

    // One clock: check combinational outputs, advance the model, then check the port.
    task automatic cycle();
        bit   ready;
        bit   pw;
        bit   deq;
        bit   had;
        ent_t e;
        ready = (q.size() < DEPTH);
        chk("stall", stall, m_stall);
        chk("lu_ready", lu_ready, ready);
        last_stall = m_stall;
        last_ready = ready;
        if (rst) begin
            q.delete();
            m_wait = 0; m_stall = 0;
            exp_en = 0; exp_addr = 5'd0; exp_data = 32'd0;
        end else begin
            had = (q.size() > 0);
            pw  = !m_stall && wb_valid && wb_wr_en && (wb_dest != 5'd0);
            deq = !pw && had;
            if (pw) begin
                exp_en = 1; exp_addr = wb_dest;
                exp_data = wb_mem_rd ? wb_mem_data : wb_alu;
            end else if (deq) begin
                e = q.pop_front();
                exp_en = 1; exp_addr = e.dest; exp_data = e.data;
            end else begin
                exp_en = 0;
            end
            if (lu_valid && ready && lu_dest != 5'd0) begin
                e.dest = lu_dest; e.data = lu_data;
                q.push_back(e);
            end
            if (had && !deq && !m_stall) m_wait++;
            else m_wait = 0;
            m_stall = !m_stall && (m_wait == LIMIT);
        end
        @(posedge clk);
        #1;
        chk("wr_en", rf_wr_en, exp_en);
        chk("wr_addr", rf_wr_addr, exp_addr);
        chk("wr_data", rf_wr_data, exp_data);
        if (rf_wr_en) wr_log.push_back(int'(rf_wr_addr));
    endtask

    int exp_seq[9] = '{1, 2, 3, 4, 5, 9, 6, 7, 8};

    initial begin
        int k;
        int li;
        int n_stall;
        int n_wr;
        rst = 1'b1;
        set_wb(0, 0, 0, 5'd0, 32'd0, 32'd0);
        set_lu(0, 5'd0, 32'd0);
        m_wait = 0; m_stall = 0; exp_en = 0; exp_addr = 5'd0; exp_data = 32'd0;
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        cycle();

        // ALU and load writes
        set_wb(1, 1, 0, 5'd5, 32'h0000_1234, 32'h0);
        cycle();
        chk("alu_en", rf_wr_en, 1'b1);
        chk("alu_addr", rf_wr_addr, 5'd5);
        chk("alu_data", rf_wr_data, 32'h0000_1234);
        set_wb(1, 1, 1, 5'd5, 32'h0000_1234, 32'hDEAD_BEEF);
        cycle();
        chk("load_data", rf_wr_data, 32'hDEAD_BEEF);
        set_wb(0, 0, 0, 5'd0, 32'd0, 32'd0);
        cycle();
        chk("idle_en", rf_wr_en, 1'b0);
        chk("idle_hold", rf_wr_data, 32'hDEAD_BEEF);

        // Long-latency result into idle pipeline: write appears at N+2
        set_lu(1, 5'd7, 32'hA5A5_A5A5);
        chk("lu7_ready", lu_ready, 1'b1);
        cycle();
        set_lu(0, 5'd0, 32'd0);
        chk("lu7_n1", rf_wr_en, 1'b0);
        cycle();
        chk("lu7_en", rf_wr_en, 1'b1);
        chk("lu7_addr", rf_wr_addr, 5'd7);
        chk("lu7_data", rf_wr_data, 32'hA5A5_A5A5);
        chk("lu7_nostall", stall, 1'b0);
        cycle();

        // Starvation: r1..r8 every cycle, one pending r9
        wr_log.delete();
        k = 1; n_stall = 0;
        for (int c = 0; c < 20 && k <= 8; c++) begin
            set_wb(1, 1, 0, 5'(k), 32'h100 + 32'(k), 32'd0);
            if (c == 0) set_lu(1, 5'd9, 32'h9999_0009);
            else set_lu(0, 5'd0, 32'd0);
            cycle();
            if (last_stall) n_stall++;
            else k++;
        end
        set_wb(0, 0, 0, 5'd0, 32'd0, 32'd0);
        cycle();
        cycle();
        chk("starve_stall_cycles", n_stall, 1);
        chk("starve_wr_count", wr_log.size(), 9);
        for (int i = 0; i < 9 && i < wr_log.size(); i++)
            chk("starve_order", wr_log[i], exp_seq[i]);

        // FIFO full: three back-to-back offers under continuous pipeline writes
        li = 0; k = 1;
        for (int c = 0; c < 16 && li < 3; c++) begin
            set_wb(1, 1, 0, 5'(k), 32'h200 + 32'(k), 32'd0);
            set_lu(1, 5'(10 + li), 32'hF000_0000 + 32'(li));
            if (c == 2) chk("full_ready3", lu_ready, 1'b0);
            cycle();
            if (!last_stall) k = (k % 8) + 1;
            if (last_ready) li++;
        end
        chk("full_all_accepted", li, 3);
        set_lu(0, 5'd0, 32'd0);
        set_wb(0, 0, 0, 5'd0, 32'd0, 32'd0);
        for (int c = 0; c < 4; c++) cycle();

        // r0 handling: pipeline r0 frees the slot; LU r0 is accepted and dropped
        set_wb(1, 1, 0, 5'd1, 32'h11, 32'd0);
        set_lu(1, 5'd12, 32'h0C0C_0C0C);
        cycle();
        set_lu(0, 5'd0, 32'd0);
        set_wb(1, 1, 0, 5'd0, 32'h77, 32'd0);
        cycle();
        chk("r0_slot_en", rf_wr_en, 1'b1);
        chk("r0_slot_addr", rf_wr_addr, 5'd12);
        set_wb(0, 0, 0, 5'd0, 32'd0, 32'd0);
        set_lu(1, 5'd0, 32'h0BAD_0000);
        chk("lu_r0_ready", lu_ready, 1'b1);
        cycle();
        set_lu(0, 5'd0, 32'd0);
        cycle();
        chk("lu_r0_nowrite", rf_wr_en, 1'b0);
        chk("lu_r0_count", lu_ready, 1'b1);

        // Reset while holding two entries in STALL
        k = 1;
        for (int c = 0; c < 20 && !m_stall; c++) begin
            set_wb(1, 1, 0, 5'(k), 32'h300 + 32'(k), 32'd0);
            set_lu(c < 2, 5'(20 + c), 32'hE000_0000 + 32'(c));
            cycle();
            if (!last_stall) k = (k % 8) + 1;
        end
        if (!m_stall) chk("rst_stall_timeout", 1'b0, 1'b1);
        chk("pre_rst_stall", stall, 1'b1);
        chk("pre_rst_ready", lu_ready, 1'b0);
        rst = 1'b1;
        set_lu(0, 5'd0, 32'd0);
        cycle();
        rst = 1'b0;
        chk("rst_en", rf_wr_en, 1'b0);
        chk("rst_addr", rf_wr_addr, 5'd0);
        chk("rst_data", rf_wr_data, 32'd0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_ready", lu_ready, 1'b1);
        set_wb(0, 0, 0, 5'd0, 32'd0, 32'd0);
        n_wr = 0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (rf_wr_en) n_wr++;
        end
        chk("rst_lost_entries", n_wr, 0);

        // Random traffic; the pipeline holds its inputs while stalled
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!last_stall) begin
                set_wb($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                       $urandom, $urandom);
            end
            set_lu($urandom_range(0, 2) == 0,
                   ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   $urandom);
            cycle();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
